// File: rtl/ctrl_pkt_arbiter_pkg.sv
// Shared widths and types for the control-stream packet arbiter.
package ctrl_pkt_arbiter_pkg;

    localparam int C_S_AXIS_DATA_WIDTH  = 512;
    localparam int C_S_AXIS_TUSER_WIDTH = 128;
    localparam int C_S_AXIS_KEEP_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_WIDTH          = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH
                                          + C_S_AXIS_KEEP_WIDTH + 1;

    typedef struct packed {
        logic                            last;
        logic [C_S_AXIS_KEEP_WIDTH-1:0]  keep;
        logic [C_S_AXIS_TUSER_WIDTH-1:0] user;
        logic [C_S_AXIS_DATA_WIDTH-1:0]  data;
    } entry_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_SEND
    } arb_state_t;

endpackage

// File: rtl/ctrl_pkt_arbiter_if.sv
// Control-stream bundle: per-port AXI-Stream sources and the merged output stream.
interface ctrl_pkt_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    import ctrl_pkt_arbiter_pkg::*;

    logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
    logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
    logic [NUM_PORTS*C_S_AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep;
    logic [NUM_PORTS-1:0]                      s_axis_tvalid;
    logic [NUM_PORTS-1:0]                      s_axis_tlast;

    logic [C_S_AXIS_DATA_WIDTH-1:0]            c_m_axis_tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]           c_m_axis_tuser;
    logic [C_S_AXIS_KEEP_WIDTH-1:0]            c_m_axis_tkeep;
    logic                                      c_m_axis_tvalid;
    logic                                      c_m_axis_tlast;

    modport slave (
        input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
    );

endinterface

// File: rtl/ctrl_pkt_fifo.sv
// Per-port packet FIFO: commits whole packets only, drops overflowing packets whole.
module ctrl_pkt_fifo
    import ctrl_pkt_arbiter_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic        axis_clk,
    input  logic        aresetn,
    input  logic        in_valid,
    input  entry_t      in_entry,
    input  logic        rd_en,
    output entry_t      rd_entry,
    output logic        pkt_avail,
    output logic [15:0] drop_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    typedef logic [FIFO_AW:0] ptr_t;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr, commit_ptr, rd_ptr;
    ptr_t pkt_cnt;
    logic dropping;
    logic full, store, commit, pop_pkt;

    // Occupancy includes the uncommitted tail, so a long packet can never wedge the FIFO.
    assign full      = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
    assign store     = in_valid && !dropping && !full;
    assign commit    = store && in_entry.last;
    assign rd_entry  = entry_t'(mem[rd_ptr[FIFO_AW-1:0]]);
    assign pop_pkt   = rd_en && rd_entry.last;
    assign pkt_avail = pkt_cnt != '0;

    always_ff @(posedge axis_clk) begin
        if (store) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= in_entry;
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            dropping   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (commit != pop_pkt) begin
                pkt_cnt <= commit ? pkt_cnt + ptr_t'(1) : pkt_cnt - ptr_t'(1);
            end
            if (in_valid) begin
                if (dropping) begin
                    if (in_entry.last) begin
                        dropping <= 1'b0;
                    end
                end else if (full) begin
                    wr_ptr   <= commit_ptr;
                    dropping <= !in_entry.last;
                    if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end else begin
                    wr_ptr <= wr_ptr + ptr_t'(1);
                    if (in_entry.last) begin
                        commit_ptr <= wr_ptr + ptr_t'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS control streams onto one registered output.
module ctrl_pkt_arbiter
    import ctrl_pkt_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int FIFO_AW   = 4
) (
    input  logic                    axis_clk,
    input  logic                    aresetn,
    ctrl_pkt_arbiter_if.slave       axis,
    output logic [NUM_PORTS*16-1:0] drop_cnt
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_KEEP_WIDTH;

    arb_state_t           state, state_n;
    logic [PW-1:0]        grant, grant_n, last_grant, last_grant_n, pick;
    logic                 found;
    logic [NUM_PORTS-1:0] rd_en, pkt_avail;
    entry_t               rd_entry [NUM_PORTS];
    entry_t               out_q, out_n;
    logic                 out_valid, out_valid_n;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        entry_t in_entry;

        assign in_entry = {axis.s_axis_tlast[p],
                           axis.s_axis_tkeep[p*KW +: KW],
                           axis.s_axis_tuser[p*UW +: UW],
                           axis.s_axis_tdata[p*DW +: DW]};

        ctrl_pkt_fifo #(
            .FIFO_AW(FIFO_AW)
        ) u_fifo (
            .axis_clk (axis_clk),
            .aresetn  (aresetn),
            .in_valid (axis.s_axis_tvalid[p]),
            .in_entry (in_entry),
            .rd_en    (rd_en[p]),
            .rd_entry (rd_entry[p]),
            .pkt_avail(pkt_avail[p]),
            .drop_cnt (drop_cnt[p*16 +: 16])
        );
    end

    // First port holding a committed packet, searching upward from last_grant+1.
    always_comb begin : rr_search
        int unsigned idx;
        idx   = 0;
        pick  = last_grant;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (32'(last_grant) + i) % NUM_PORTS;
            if (!found && pkt_avail[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        rd_en        = '0;
        out_n        = '0;
        out_valid_n  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    grant_n = pick;
                    state_n = ARB_SEND;
                end
            end
            ARB_SEND: begin
                rd_en[grant] = 1'b1;
                out_n        = rd_entry[grant];
                out_valid_n  = 1'b1;
                if (rd_entry[grant].last) begin
                    last_grant_n = grant;
                    state_n      = ARB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= PW'(NUM_PORTS - 1);
            out_q      <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            out_q      <= out_n;
            out_valid  <= out_valid_n;
        end
    end

    assign axis.c_m_axis_tdata  = out_q.data;
    assign axis.c_m_axis_tuser  = out_q.user;
    assign axis.c_m_axis_tkeep  = out_q.keep;
    assign axis.c_m_axis_tlast  = out_q.last;
    assign axis.c_m_axis_tvalid = out_valid;

endmodule
